// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state type, keycodes and BCD score helper
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam logic [15:0] KEY_START = 16'h002C;
  localparam logic [15:0] KEY_UP    = 16'h001A;

  // {tens, ones}
  typedef logic [7:0] bcd8_t;

  // BCD increment that sticks at 99
  function automatic bcd8_t bcd_inc_sat(input bcd8_t v);
    bcd8_t r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - frame_clk synchroniser with registered rising-edge pulse
// Ports: Clk, Reset (sync, active-high), frame_clk (async in), frame_tick (1-Clk pulse, 3 Clk after rise)
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;
  logic tick_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      // registered edge detect keeps the pulse glitch-free for downstream logic
      tick_q  <= sync2_q & ~sync3_q;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game FSM: start detect, collision, BCD scoring, high score
// Ports: Clk, Reset (sync, active-high), frame_clk, keyboard, BallX/BallY/BallS, PipeX, PipeGapY in;
//        ball_reset, game_state, score, high_score, dead_pulse out
module game_state_ctrl
  import game_pkg::*;
#(
  parameter logic [9:0] PIPE_W      = 10'd40,
  parameter logic [9:0] GAP_H       = 10'd120,
  parameter logic [9:0] FLOOR_Y     = 10'd479,
  parameter logic [7:0] DEAD_FRAMES = 8'd90
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [15:0] keyboard,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  BallS,
  input  logic [9:0]  PipeX,
  input  logic [9:0]  PipeGapY,
  output logic        ball_reset,
  output logic [1:0]  game_state,
  output logic [7:0]  score,
  output logic [7:0]  high_score,
  output logic        dead_pulse
);

  logic frame_tick;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  game_state_t state_q;
  logic        ball_reset_q;
  bcd8_t       score_q;
  bcd8_t       high_q;
  logic        dead_pulse_q;
  logic [7:0]  cnt_q;
  logic        key_prev_q;
  logic        passed_q;
  logic [9:0]  pipe_prev_q;

  logic        key_hit;
  logic        start;
  logic [10:0] left, right, top, bot, pipe_r, gap_b;
  logic        collide;
  logic        pass;
  logic        respawn;

  always_comb begin
    key_hit = (keyboard == KEY_START);
    start   = key_hit && !key_prev_q;

    left   = (BallS > BallX) ? 11'd0 : ({1'b0, BallX} - {1'b0, BallS});
    right  = {1'b0, BallX} + {1'b0, BallS};
    top    = (BallS > BallY) ? 11'd0 : ({1'b0, BallY} - {1'b0, BallS});
    bot    = {1'b0, BallY} + {1'b0, BallS};
    pipe_r = {1'b0, PipeX} + {1'b0, PIPE_W};
    gap_b  = {1'b0, PipeGapY} + {1'b0, GAP_H};

    collide = (bot >= {1'b0, FLOOR_Y}) || (top == 11'd0) ||
              ((right >= {1'b0, PipeX}) && (left <= pipe_r) &&
               ((top < {1'b0, PipeGapY}) || (bot > gap_b)));
    pass    = (pipe_r < left) && !passed_q;
    // pipe scroller wrapped back to the right edge
    respawn = (PipeX > pipe_prev_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      ball_reset_q <= 1'b1;
      score_q      <= 8'h00;
      high_q       <= 8'h00;
      dead_pulse_q <= 1'b0;
      cnt_q        <= 8'd0;
      key_prev_q   <= 1'b0;
      passed_q     <= 1'b0;
      pipe_prev_q  <= 10'd0;
    end else begin
      key_prev_q   <= key_hit;
      dead_pulse_q <= 1'b0;
      if (frame_tick) begin
        pipe_prev_q <= PipeX;
      end
      case (state_q)
        IDLE: begin
          ball_reset_q <= 1'b1;
          if (start) begin
            state_q      <= PLAY;
            score_q      <= 8'h00;
            passed_q     <= 1'b0;
            ball_reset_q <= 1'b0;
          end
        end
        PLAY: begin
          ball_reset_q <= 1'b0;
          if (frame_tick) begin
            // collision has priority over a pass on the same frame
            if (collide) begin
              state_q      <= DEAD;
              dead_pulse_q <= 1'b1;
              cnt_q        <= DEAD_FRAMES;
              if (score_q > high_q) begin
                high_q <= score_q;
              end
            end else if (pass) begin
              passed_q <= 1'b1;
              score_q  <= bcd_inc_sat(score_q);
            end else if (respawn) begin
              passed_q <= 1'b0;
            end
          end
        end
        DEAD: begin
          ball_reset_q <= 1'b0;
          if (frame_tick) begin
            if (cnt_q == 8'd0) begin
              state_q      <= IDLE;
              ball_reset_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          ball_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign ball_reset = ball_reset_q;
  assign game_state = state_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign dead_pulse = dead_pulse_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - scoreboard bench for game_state_ctrl
module tb_game_state_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [15:0] keyboard;
  logic [9:0]  BallX, BallY, BallS, PipeX, PipeGapY;
  logic        ball_reset;
  logic [1:0]  game_state;
  logic [7:0]  score, high_score;
  logic        dead_pulse;

  game_state_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .keyboard  (keyboard),
    .BallX     (BallX),
    .BallY     (BallY),
    .BallS     (BallS),
    .PipeX     (PipeX),
    .PipeGapY  (PipeGapY),
    .ball_reset(ball_reset),
    .game_state(game_state),
    .score     (score),
    .high_score(high_score),
    .dead_pulse(dead_pulse)
  );

  always #10 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [7:0] sc;
    logic [7:0] hi;
    logic       br;
  } exp_t;

  exp_t sb[$];

  // reference model
  int         m_state  = 0;
  logic [7:0] m_score  = 8'h00;
  logic [7:0] m_high   = 8'h00;
  bit         m_passed = 0;
  int         m_prev   = 0;
  int         m_cnt    = 0;

  function automatic logic [7:0] dec_inc(input logic [7:0] b);
    int d;
    d = b[7:4] * 10 + b[3:0];
    if (d < 99) d++;
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic model_tick(input int bx, input int by, input int bs, input int px, input int gy,
                            input string tag);
    int l, r, t, b;
    bit col, pas, resp;
    exp_t e;
    l = (bs > bx) ? 0 : bx - bs;
    r = bx + bs;
    t = (bs > by) ? 0 : by - bs;
    b = by + bs;
    col  = (b >= 479) || (t == 0) || ((r >= px) && (l <= px + 40) && ((t < gy) || (b > gy + 120)));
    pas  = (px + 40 < l) && !m_passed;
    resp = px > m_prev;
    if (m_state == 1) begin
      if (col) begin
        m_state = 2;
        m_cnt   = 90;
        if (m_score > m_high) m_high = m_score;
      end else if (pas) begin
        m_passed = 1;
        m_score  = dec_inc(m_score);
      end else if (resp) begin
        m_passed = 0;
      end
    end else if (m_state == 2) begin
      if (m_cnt == 0) m_state = 0;
      else m_cnt--;
    end
    m_prev = px;
    e.tag = tag;
    e.st  = 2'(m_state);
    e.sc  = m_score;
    e.hi  = m_high;
    e.br  = (m_state == 0);
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_state"}, game_state, e.st);
      check({e.tag, "_score"}, score, e.sc);
      check({e.tag, "_high"}, high_score, e.hi);
      check({e.tag, "_ball_reset"}, ball_reset, e.br);
    end
  endtask

  task automatic frame(input int bx, input int by, input int bs, input int px, input int gy,
                       input string tag);
    @(negedge Clk);
    BallX = 10'(bx); BallY = 10'(by); BallS = 10'(bs);
    PipeX = 10'(px); PipeGapY = 10'(gy);
    model_tick(bx, by, bs, px, gy, tag);
    frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    check_out();
  endtask

  task automatic press_start();
    @(negedge Clk);
    keyboard = 16'h002C;
    if (m_state == 0) begin
      m_state  = 1;
      m_score  = 8'h00;
      m_passed = 0;
    end
    repeat (3) @(negedge Clk);
    keyboard = 16'h0000;
  endtask

  task automatic do_pass(input string tag);
    frame(320, 240, 4, 500, 180, {tag, "_respawn"});
    frame(320, 240, 4, 200, 180, {tag, "_pass"});
  endtask

  task automatic wait_dead(input string tag);
    for (int i = 0; i < 91; i++) begin
      frame(320, 240, 4, 500, 180, $sformatf("%s_dead%0d", tag, i));
      if (i == 40) press_start();
    end
  endtask

  // monitors
  int   idle2play = 0;
  int   dp_cycles = 0;
  int   dp_run    = 0;
  int   dp_maxrun = 0;
  logic [1:0] prev_state = 2'd0;

  always @(negedge Clk) begin
    if (prev_state == 2'd0 && game_state == 2'd1) idle2play++;
    prev_state = game_state;
    if (dead_pulse === 1'b1) begin
      dp_cycles++;
      dp_run++;
      if (dp_run > dp_maxrun) dp_maxrun = dp_run;
    end else begin
      dp_run = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    Reset = 1'b1; frame_clk = 1'b0; keyboard = 16'h0;
    BallX = 10'd320; BallY = 10'd240; BallS = 10'd4; PipeX = 10'd500; PipeGapY = 10'd180;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check("rst_state", game_state, 0);
    check("rst_ball_reset", ball_reset, 1);
    check("rst_score", score, 0);
    check("rst_high", high_score, 0);
    check("rst_dead_pulse", dead_pulse, 0);

    // frame_tick latency, while idle
    @(negedge Clk);
    model_tick(320, 240, 4, 500, 180, "lat");
    frame_clk = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      check($sformatf("tick_lat%0d", i), dut.u_tick.frame_tick, (i == 3) ? 1 : 0);
    end
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    check_out();

    // 1: held start key
    idle2play = 0;
    @(negedge Clk);
    keyboard = 16'h002C;
    m_state = 1; m_score = 8'h00; m_passed = 0;
    check("t1_br_before", ball_reset, 1);
    @(negedge Clk);
    check("t1_br_after", ball_reset, 0);
    check("t1_state", game_state, 1);
    repeat (1000) @(negedge Clk);
    check("t1_one_start", idle2play, 1);
    check("t1_score", score, 8'h00);
    keyboard = 16'h0;

    // 2: scrolling pipe, one pass at PipeX=274
    for (int px = 400; px >= 260; px -= 2)
      frame(320, 240, 4, px, 180, $sformatf("t2_px%0d", px));
    check("t2_score", score, 8'h01);

    // 3: pipe collision
    base = dp_cycles;
    frame(320, 150, 4, 300, 180, "t3_hit");
    check("t3_pulse_width", dp_cycles - base, 1);
    check("t3_high", high_score, 8'h01);
    wait_dead("t3");
    check("t3_idle_after", game_state, 0);

    // 4: floor collision, start ignored in DEAD
    press_start();
    frame(320, 476, 4, 500, 180, "t4_floor");
    check("t4_state", game_state, 2);
    wait_dead("t4");
    check("t4_ball_reset", ball_reset, 1);

    // 5: BCD carry and saturation
    press_start();
    for (int i = 0; i < 9; i++) do_pass("t5");
    check("t5_09", score, 8'h09);
    do_pass("t5c");
    check("t5_10", score, 8'h10);
    for (int i = 0; i < 89; i++) do_pass("t5s");
    check("t5_99", score, 8'h99);
    do_pass("t5sat");
    check("t5_sat", score, 8'h99);
    frame(320, 476, 4, 500, 180, "t5_die");
    check("t5_high", high_score, 8'h99);
    wait_dead("t5");

    // 6: collision and pass together, then reset mid-round
    press_start();
    do_pass("t6");
    do_pass("t6");
    frame(320, 240, 4, 500, 180, "t6_respawn");
    frame(320, 478, 4, 200, 180, "t6_both");
    check("t6_score_kept", score, 8'h02);
    check("t6_state", game_state, 2);
    wait_dead("t6");
    press_start();
    do_pass("t6r");
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    m_state = 0; m_score = 8'h00; m_high = 8'h00; m_passed = 0; m_prev = 0; m_cnt = 0;
    check("t6_rst_state", game_state, 0);
    check("t6_rst_ball_reset", ball_reset, 1);
    check("t6_rst_score", score, 0);
    check("t6_rst_high", high_score, 0);
    check("t6_rst_dead_pulse", dead_pulse, 0);
    check("dead_pulse_max_run", dp_maxrun, 1);
    frame(320, 240, 4, 500, 180, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
